// File: rtl/instr_sequencer_if.sv
// Bundle of the sequencer's run control, fetch, decode and execute signals.
// master: the sequencer drives requests and status and receives acks, data and done.
// slave:  the environment (memory, decoder, datapath, host) side of the same signals.
//
// Signals:
//   SEQ_start          host run request
//   fetch_req/_addr    instruction-memory read request and address
//   fetch_ack/_data    memory response valid and instruction word
//   dec_instruction    latched instruction register, dec_valid marks the DECODE cycle
//   exec_start         one-cycle dispatch pulse; exec_opcode/p1/p2 are the IR fields
//   exec_done          datapath completion
//   pc, busy, halted, error, err_code   status
interface instr_sequencer_if;
  logic        SEQ_start;
  logic        fetch_req;
  logic [5:0]  fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic [15:0] dec_instruction;
  logic        dec_valid;
  logic        exec_start;
  logic [3:0]  exec_opcode;
  logic [5:0]  exec_p1;
  logic [5:0]  exec_p2;
  logic        exec_done;
  logic [5:0]  pc;
  logic        busy;
  logic        halted;
  logic        error;
  logic [1:0]  err_code;

  modport master (
    input  SEQ_start,
    input  fetch_ack,
    input  fetch_data,
    input  exec_done,
    output fetch_req,
    output fetch_addr,
    output dec_instruction,
    output dec_valid,
    output exec_start,
    output exec_opcode,
    output exec_p1,
    output exec_p2,
    output pc,
    output busy,
    output halted,
    output error,
    output err_code
  );

  modport slave (
    output SEQ_start,
    output fetch_ack,
    output fetch_data,
    output exec_done,
    input  fetch_req,
    input  fetch_addr,
    input  dec_instruction,
    input  dec_valid,
    input  exec_start,
    input  exec_opcode,
    input  exec_p1,
    input  exec_p2,
    input  pc,
    input  busy,
    input  halted,
    input  error,
    input  err_code
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch -> decode -> execute -> wait-for-done loop with jump, halt and faults.
// Latency: fetch_ack in N -> dec_valid in N+1 -> exec_start in N+2; exec_done in M -> fetch_req in M+1.
// Backpressure: holds FETCH until fetch_ack (faults after ACK_TIMEOUT cycles), holds WAIT until exec_done.
//
// Ports:
//   SEQ_clock  sole clock, rising edge
//   SEQ_reset  asynchronous active-low reset; clears state, pc, IR, counter and all outputs
//   bus        instr_sequencer_if.master (see interface file for the signal list)
module instr_sequencer #(
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                 SEQ_clock,
  input  logic                 SEQ_reset,
  instr_sequencer_if.master    bus
);

  // Counter must hold 0..ACK_TIMEOUT-1.
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [3:0] OP_LAST_ALU = 4'd10;
  localparam logic [3:0] OP_JMP      = 4'd11;
  localparam logic [3:0] OP_HALT     = 4'd12;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         pc_q, pc_d;
  logic [15:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         err_q, err_d;

  // Registered Moore outputs, loaded from the next-state decode.
  logic               fetch_req_q;
  logic               dec_valid_q;
  logic               exec_start_q;
  logic               busy_q;
  logic               halted_q;
  logic               error_q;

  logic [3:0]         ir_op;
  logic [5:0]         ir_p1;

  assign ir_op = ir_q[15:12];
  assign ir_p1 = ir_q[11:6];

  // Next-state logic. The timeout counter defaults to zero so it is
  // cleared on every entry into FETCH, whatever the source state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = '0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.SEQ_start) begin
          pc_d    = 6'd0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (bus.fetch_ack) begin
          ir_d    = bus.fetch_data;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // This was the last allowed FETCH cycle without an ack.
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        if (ir_op <= OP_LAST_ALU) begin
          state_d = S_WAIT;
        end else if (ir_op == OP_JMP) begin
          pc_d    = ir_p1;
          state_d = S_FETCH;
        end else if (ir_op == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_ERROR;
          err_d   = ERR_ILLEGAL;
        end
      end

      S_WAIT: begin
        if (bus.exec_done) begin
          pc_d    = pc_q + 6'd1;  // 6-bit add wraps 63 -> 0
          state_d = S_FETCH;
        end
      end

      S_HALTED: begin
        if (bus.SEQ_start) begin
          pc_d    = 6'd0;
          state_d = S_FETCH;
        end
      end

      S_ERROR: begin
        state_d = S_ERROR;  // sticky until reset
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SEQ_clock or negedge SEQ_reset) begin
    if (!SEQ_reset) begin
      state_q      <= S_IDLE;
      pc_q         <= 6'd0;
      ir_q         <= 16'd0;
      cnt_q        <= '0;
      err_q        <= ERR_NONE;
      fetch_req_q  <= 1'b0;
      dec_valid_q  <= 1'b0;
      exec_start_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fetch_req_q  <= (state_d == S_FETCH);
      dec_valid_q  <= (state_d == S_DECODE);
      // IR is stable from DECODE onward, so ir_d already holds the word to dispatch.
      exec_start_q <= (state_d == S_EXECUTE) && (ir_d[15:12] <= OP_LAST_ALU);
      busy_q       <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                      (state_d == S_EXECUTE) || (state_d == S_WAIT);
      halted_q     <= (state_d == S_HALTED);
      error_q      <= (state_d == S_ERROR);
    end
  end

  assign bus.fetch_req       = fetch_req_q;
  assign bus.fetch_addr      = pc_q;
  assign bus.dec_instruction = ir_q;
  assign bus.dec_valid       = dec_valid_q;
  assign bus.exec_start      = exec_start_q;
  assign bus.exec_opcode     = ir_q[15:12];
  assign bus.exec_p1         = ir_q[11:6];
  assign bus.exec_p2         = ir_q[5:0];
  assign bus.pc              = pc_q;
  assign bus.busy            = busy_q;
  assign bus.halted          = halted_q;
  assign bus.error           = error_q;
  assign bus.err_code        = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed programs, expected events queued up front and
// compared by an independent monitor as the DUT produces them.
module tb_instr_sequencer;

  localparam int ACK_TIMEOUT = 8;

  localparam logic [1:0] EV_FETCH = 2'd0;
  localparam logic [1:0] EV_EXEC  = 2'd1;
  localparam logic [1:0] EV_HALT  = 2'd2;
  localparam logic [1:0] EV_ERR   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] data;
  } ev_t;

  logic clk;
  logic rst_n;

  instr_sequencer_if bus ();

  instr_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .SEQ_clock (clk),
    .SEQ_reset (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ev_t         exp_q[$];
  int          vectors = 0;
  int          fails   = 0;
  logic [15:0] mem [64];

  // Environment knobs
  bit ack_en     = 1'b1;
  bit dp_en      = 1'b1;
  bit junk       = 1'b0;
  int ack_delay  = 0;
  int done_delay = 0;

  // Monitor bookkeeping
  int cyc        = 0;
  int ack_cyc    = -100;
  int done_cyc   = -100;
  int frise_cyc  = -100;
  bit done_pend  = 1'b0;
  int fetch_seen = 0;
  logic prev_fetch, prev_halted, prev_error;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] act);
    vectors++;
    fails++;
    $display("FAIL %s: got %0h, required nothing", name, act);
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [15:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      report_fail("unexpected_event", {14'd0, kind, data});
    end else begin
      e = exp_q.pop_front();
      check("event_kind", {30'd0, kind}, {30'd0, e.kind});
      check("event_data", {16'd0, data}, {16'd0, e.data});
    end
  endtask

  // Instruction memory responder
  initial begin
    int acnt;
    acnt = 0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 16'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.fetch_ack = 1'b0;
        acnt = 0;
      end else if (junk) begin
        bus.fetch_ack  = 1'b1;
        bus.fetch_data = 16'hFFFF;
      end else if (bus.fetch_req && ack_en) begin
        if (acnt == ack_delay) begin
          bus.fetch_ack  = 1'b1;
          bus.fetch_data = mem[bus.fetch_addr];
        end else begin
          bus.fetch_ack = 1'b0;
        end
        acnt++;
      end else begin
        bus.fetch_ack = 1'b0;
        acnt = 0;
      end
    end
  end

  // Datapath responder
  initial begin
    int dcnt;
    bit pend;
    dcnt = 0;
    pend = 1'b0;
    bus.exec_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.exec_done = 1'b0;
        pend = 1'b0;
      end else if (junk) begin
        bus.exec_done = 1'b1;
      end else if (bus.exec_start) begin
        pend = 1'b1;
        dcnt = 0;
        bus.exec_done = 1'b0;
      end else if (pend && dp_en) begin
        if (dcnt == done_delay) begin
          bus.exec_done = 1'b1;
          pend = 1'b0;
        end else begin
          bus.exec_done = 1'b0;
          dcnt++;
        end
      end else begin
        bus.exec_done = 1'b0;
      end
    end
  end

  // Monitor: turns DUT outputs into events and checks cycle relationships.
  initial begin
    prev_fetch  = 1'b0;
    prev_halted = 1'b0;
    prev_error  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) done_pend = 1'b0;
      if (bus.fetch_req && bus.fetch_ack) ack_cyc = cyc;
      if (bus.dec_valid) check("dec_valid_latency", cyc, ack_cyc + 1);
      if (bus.exec_done && bus.busy && !bus.fetch_req && !bus.dec_valid && !bus.exec_start) begin
        done_cyc  = cyc;
        done_pend = 1'b1;
      end
      if (bus.fetch_req && !prev_fetch) begin
        if (done_pend) begin
          check("done_to_fetch_latency", cyc, done_cyc + 1);
          done_pend = 1'b0;
        end
        frise_cyc = cyc;
        fetch_seen++;
        observe(EV_FETCH, {10'd0, bus.fetch_addr});
      end
      if (bus.exec_start) begin
        check("exec_start_latency", cyc, ack_cyc + 2);
        observe(EV_EXEC, {bus.exec_opcode, bus.exec_p1, bus.exec_p2});
      end
      if (bus.halted && !prev_halted) observe(EV_HALT, 16'd0);
      if (bus.error && !prev_error) begin
        if (bus.err_code == 2'b01) check("timeout_cycles", cyc - frise_cyc, ACK_TIMEOUT);
        observe(EV_ERR, {14'd0, bus.err_code});
      end
      prev_fetch  = bus.fetch_req;
      prev_halted = bus.halted;
      prev_error  = bus.error;
    end
  end

  // which: 0 halted, 1 error, 2 pc==val, 3 exec_start, 4 fetch_seen>=val
  task automatic wait_cond(input int which, input int val, input int bound, input string name);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < bound) begin
      @(negedge clk);
      n++;
      case (which)
        0:       ok = bus.halted;
        1:       ok = bus.error;
        2:       ok = (int'(bus.pc) == val);
        3:       ok = bus.exec_start;
        4:       ok = (fetch_seen >= val);
        default: ok = 1'b1;
      endcase
    end
    if (!ok) report_fail({"wait_timeout_", name}, n);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.SEQ_start = 1'b1;
    @(negedge clk);
    bus.SEQ_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.SEQ_start = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",       bus.busy, 0);
    check("rst_halted",     bus.halted, 0);
    check("rst_error",      bus.error, 0);
    check("rst_fetch_req",  bus.fetch_req, 0);
    check("rst_exec_start", bus.exec_start, 0);
    check("rst_dec_valid",  bus.dec_valid, 0);
    check("rst_pc",         bus.pc, 0);
    check("rst_ir",         bus.dec_instruction, 0);
    check("rst_err_code",   bus.err_code, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Stray ack/done/data in IDLE must not move the block.
    junk = 1'b1;
    repeat (4) @(negedge clk);
    junk = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_pc",   bus.pc, 0);
    check("idle_ir",   bus.dec_instruction, 0);
    check("idle_freq", bus.fetch_req, 0);

    // Basic ALU instruction then halt; extra start while busy is ignored.
    mem[0] = 16'h1041;
    mem[1] = 16'hC000;
    done_delay = 3;
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_EXEC,  16'h1041);
    expect_ev(EV_FETCH, 16'd1);
    expect_ev(EV_HALT,  16'd0);
    pulse_start();
    wait_cond(3, 0, 20, "exec_a");
    pulse_start();
    wait_cond(0, 0, 30, "halt_a");
    drain("alu");
    check("halt_halted", bus.halted, 1);
    check("halt_busy",   bus.busy, 0);
    check("halt_pc",     bus.pc, 1);
    done_delay = 0;

    // Restart from HALTED.
    mem[0] = 16'hC000;
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_HALT,  16'd0);
    @(negedge clk);
    bus.SEQ_start = 1'b1;
    @(negedge clk);
    bus.SEQ_start = 1'b0;
    check("restart_busy", bus.busy, 1);
    check("restart_addr", bus.fetch_addr, 0);
    wait_cond(0, 0, 20, "halt_restart");
    drain("restart");

    // JMP 10, no dispatch.
    do_reset();
    mem[0]  = 16'hB280;
    mem[10] = 16'hC000;
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_FETCH, 16'd10);
    expect_ev(EV_HALT,  16'd0);
    pulse_start();
    wait_cond(0, 0, 30, "halt_jmp");
    drain("jmp");
    check("jmp_pc", bus.pc, 10);

    // JMP to own address loops without fault.
    do_reset();
    mem[0] = 16'hB000;
    for (int i = 0; i < 4; i++) expect_ev(EV_FETCH, 16'd0);
    base = fetch_seen;
    pulse_start();
    wait_cond(4, base + 4, 40, "self_loop");
    check("self_loop_error", bus.error, 0);
    do_reset();
    drain("self_loop");

    // Run all 64 addresses with op 0; pc wraps 63 -> 0, then halt at 0.
    // SEQ_start is held high while busy and must be ignored.
    do_reset();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    ack_delay  = 1;
    done_delay = 1;
    for (int k = 0; k < 64; k++) begin
      expect_ev(EV_FETCH, 16'(k));
      expect_ev(EV_EXEC,  16'h0000);
    end
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_HALT,  16'd0);
    @(negedge clk);
    bus.SEQ_start = 1'b1;
    wait_cond(2, 1, 30, "wrap_pc1");
    mem[0] = 16'hC000;
    wait_cond(2, 63, 1000, "wrap_pc63");
    bus.SEQ_start = 1'b0;
    wait_cond(0, 0, 50, "wrap_halt");
    drain("wrap");
    check("wrap_pc", bus.pc, 0);
    ack_delay  = 0;
    done_delay = 0;

    // Ack on the last allowed FETCH cycle is accepted.
    do_reset();
    mem[0] = 16'hC000;
    ack_delay = ACK_TIMEOUT - 1;
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_HALT,  16'd0);
    pulse_start();
    wait_cond(0, 0, 40, "late_ack_halt");
    drain("late_ack");
    check("late_ack_error", bus.error, 0);
    ack_delay = 0;

    // No ack at all: fetch timeout, then start is ignored.
    do_reset();
    ack_en = 1'b0;
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_ERR,   16'd1);
    pulse_start();
    wait_cond(1, 0, 40, "timeout_err");
    drain("timeout");
    pulse_start();
    repeat (4) @(negedge clk);
    check("timeout_error",    bus.error, 1);
    check("timeout_err_code", bus.err_code, 2'b01);
    check("timeout_busy",     bus.busy, 0);
    check("timeout_freq",     bus.fetch_req, 0);

    // Reset mid-FETCH drops fetch_req immediately.
    do_reset();
    expect_ev(EV_FETCH, 16'd0);
    pulse_start();
    repeat (3) @(negedge clk);
    drain("mid_fetch");
    #3 rst_n = 1'b0;
    #1;
    check("midfetch_freq", bus.fetch_req, 0);
    check("midfetch_busy", bus.busy, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    check("midfetch_idle", bus.busy, 0);

    // Opcode 10 dispatches, opcode 13 is illegal.
    do_reset();
    mem[0] = 16'hA000;
    mem[1] = 16'hD000;
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_EXEC,  16'hA000);
    expect_ev(EV_FETCH, 16'd1);
    expect_ev(EV_ERR,   16'd2);
    pulse_start();
    wait_cond(1, 0, 30, "illegal_d");
    drain("illegal_d");
    pulse_start();
    repeat (3) @(negedge clk);
    check("illegal_error",    bus.error, 1);
    check("illegal_err_code", bus.err_code, 2'b10);
    check("illegal_busy",     bus.busy, 0);

    // Opcode 14 is illegal.
    do_reset();
    mem[0] = 16'hE000;
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_ERR,   16'd2);
    pulse_start();
    wait_cond(1, 0, 30, "illegal_e");
    drain("illegal_e");
    check("illegal_e_code", bus.err_code, 2'b10);

    // Reset between edges while in WAIT.
    do_reset();
    dp_en  = 1'b0;
    mem[0] = 16'hB140;
    mem[5] = 16'h3000;
    expect_ev(EV_FETCH, 16'd0);
    expect_ev(EV_FETCH, 16'd5);
    expect_ev(EV_EXEC,  16'h3000);
    pulse_start();
    wait_cond(3, 0, 30, "wait_exec");
    repeat (3) @(negedge clk);
    drain("wait_reset");
    check("inwait_busy", bus.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("wreset_busy",  bus.busy, 0);
    check("wreset_pc",    bus.pc, 0);
    check("wreset_exec",  bus.exec_start, 0);
    check("wreset_ir",    bus.dec_instruction, 0);
    check("wreset_freq",  bus.fetch_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dp_en = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_busy", bus.busy, 0);
    check("post_reset_pc",   bus.pc, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
